// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: RV32I load/store size encodings
// and the clear/ready controller states.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } dmem_state_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Load data path: picks the addressed byte/half out of a 32-bit word and
// sign- or zero-extends it according to funct3.
module dmem_load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      F3_W:    o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed RV32I data memory with per-lane stores, access-error detection,
// optional post-reset clear sweep and combinational or registered read.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned READ_LATENCY   = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        re,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        rd_valid,
  output logic        busy,
  output logic        acc_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  dmem_state_t   r_state, w_state_nxt;
  logic [AW-1:0] r_clr_idx;

  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_ready;
  logic          w_misalign;
  logic          w_err;
  logic          w_store_ok;
  logic          w_load_ok;
  logic [3:0]    w_mask;
  logic [31:0]   w_wdata;
  logic [31:0]   w_word;
  logic [31:0]   w_ext;
  logic          w_unused;

  // Upper address bits are deliberately dropped so accesses wrap modulo DEPTH.
  assign w_idx    = addr[AW+1:2];
  assign w_lane   = addr[1:0];
  assign w_unused = ^addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET) r_state <= ST_CLEAR;
      else                r_state <= ST_READY;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_idx == '1) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_READY;
    endcase
  end

  assign w_ready = (r_state == ST_READY);
  assign busy    = ~w_ready;

  assign w_misalign = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0])
                    || ((funct3 == F3_W) && (addr[1:0] != 2'b00));
  // A store with an unsigned size kills the whole request, including a paired load.
  assign w_err      = (we | re) & (~f3_legal(funct3) | (we & funct3[2]) | w_misalign);
  assign acc_err    = w_err & w_ready;
  assign w_store_ok = we & w_ready & ~w_err;
  assign w_load_ok  = re & w_ready & ~w_err;

  always_comb begin
    w_mask  = '0;
    w_wdata = wd;
    case (funct3)
      F3_B: begin
        w_mask  = 4'b0001 << w_lane;
        w_wdata = {4{wd[7:0]}};
      end
      F3_H: begin
        w_mask  = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wd[15:0]}};
      end
      F3_W:    w_mask = '1;
      default: w_mask = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_store_ok) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_mask[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // Reading the array before the edge gives read-before-write for same-cycle we/re.
  assign w_word = r_mem[w_idx];

  dmem_load_extend u_load_extend (
    .i_word   (w_word),
    .i_lane   (w_lane),
    .i_funct3 (funct3),
    .o_data   (w_ext)
  );

  if (READ_LATENCY == 0) begin : g_rd_comb
    assign rd       = w_load_ok ? w_ext : '0;
    assign rd_valid = w_load_ok;
  end else begin : g_rd_reg
    logic [31:0] r_rd;
    logic        r_rd_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd       <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_load_ok;
        if (w_load_ok) r_rd <= w_ext;
      end
    end

    assign rd       = r_rd;
    assign rd_valid = r_rd_valid;
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed self-checking bench: one combinational-read and one registered-read
// instance (DEPTH=16, clear on reset) driven by the same request stream.
module tb_dmem_bytelane;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        we;
  logic        re;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd0, rd1;
  logic        rdv0, rdv1;
  logic        busy0, busy1;
  logic        err0, err1;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_bytelane #(
    .DEPTH          (16),
    .READ_LATENCY   (0),
    .CLEAR_ON_RESET (1'b1)
  ) u_dut0 (
    .clk (clk), .rst (rst), .we (we), .re (re), .funct3 (funct3), .addr (addr),
    .wd (wd), .rd (rd0), .rd_valid (rdv0), .busy (busy0), .acc_err (err0)
  );

  dmem_bytelane #(
    .DEPTH          (16),
    .READ_LATENCY   (1),
    .CLEAR_ON_RESET (1'b1)
  ) u_dut1 (
    .clk (clk), .rst (rst), .we (we), .re (re), .funct3 (funct3), .addr (addr),
    .wd (wd), .rd (rd1), .rd_valid (rdv1), .busy (busy1), .acc_err (err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every task leaves time parked 1 ns after a rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    we = w; re = r; funct3 = f3; addr = a; wd = d;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, f3, a, d);
    step;
    idle;
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] exp);
    drive(1'b0, 1'b1, f3, a, 32'h0);
    @(negedge clk);
    check({tag, "_rd0"}, rd0, exp);
    check({tag, "_rdv0"}, {31'd0, rdv0}, 32'd1);
    step;
    check({tag, "_rd1"}, rd1, exp);
    check({tag, "_rdv1"}, {31'd0, rdv1}, 32'd1);
  endtask

  task automatic bad_req(input string tag, input logic w, input logic r,
                         input logic [2:0] f3, input logic [31:0] a);
    drive(w, r, f3, a, 32'hDEAD_BEEF);
    @(negedge clk);
    check({tag, "_err"}, {31'd0, err0}, 32'd1);
    check({tag, "_rd0"}, rd0, 32'h0);
    check({tag, "_rdv0"}, {31'd0, rdv0}, 32'd0);
    step;
    check({tag, "_rdv1"}, {31'd0, rdv1}, 32'd0);
    idle;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy0 === 1'b1 && n < 100) begin
      step;
      n++;
    end
  endtask

  int n_busy;

  initial begin
    rst = 1'b1;
    idle;
    step;
    step;
    check("rst_busy0", {31'd0, busy0}, 32'd1);
    check("rst_busy1", {31'd0, busy1}, 32'd1);
    check("rst_rd1", rd1, 32'h0);
    check("rst_rdv1", {31'd0, rdv1}, 32'd0);
    check("rst_rdv0", {31'd0, rdv0}, 32'd0);
    check("rst_err0", {31'd0, err0}, 32'd0);

    rst = 1'b0;
    wait_ready(n_busy);
    check("sweep_cycles", n_busy, 32'd16);
    check("ready_busy1", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    check("idle_rd0", rd0, 32'h0);
    step;

    for (int i = 0; i < 16; i++) load("lw_zero", F3_W, 32'(i * 4), 32'h0);

    // Lane extraction and sign/zero extension
    store(F3_W, 32'h8, 32'h80FF_7F01);
    load("lb8",   F3_B,  32'h8, 32'h0000_0001);
    load("lb9",   F3_B,  32'h9, 32'h0000_007F);
    load("lbA",   F3_B,  32'hA, 32'hFFFF_FFFF);
    load("lbuA",  F3_BU, 32'hA, 32'h0000_00FF);
    load("lhA",   F3_H,  32'hA, 32'hFFFF_80FF);
    load("lhuA",  F3_HU, 32'hA, 32'h0000_80FF);
    load("lbu8",  F3_BU, 32'hB, 32'h0000_0080);

    // Partial stores leave other lanes untouched; upper wd bits ignored
    store(F3_W, 32'h10, 32'h0);
    store(F3_B, 32'h13, 32'hFFFF_FFAB);
    store(F3_H, 32'h10, 32'hFFFF_1234);
    load("merge10", F3_W, 32'h10, 32'hAB00_1234);
    store(F3_W, 32'h14, 32'h0);
    store(F3_H, 32'h16, 32'hAAAA_5678);
    load("merge14", F3_W, 32'h14, 32'h5678_0000);

    // Access errors suppress the whole request
    store(F3_W, 32'h4, 32'hCAFE_BABE);
    bad_req("sw_mis",  1'b1, 1'b0, F3_W,   32'h6);
    bad_req("lh_mis",  1'b0, 1'b1, F3_H,   32'h5);
    bad_req("f3_011",  1'b0, 1'b1, 3'b011, 32'h4);
    bad_req("sbu",     1'b1, 1'b1, F3_BU,  32'h4);
    bad_req("shu_mis", 1'b1, 1'b0, F3_HU,  32'h7);
    load("after_err", F3_W, 32'h4, 32'hCAFE_BABE);
    load("lh6",       F3_H, 32'h6, 32'hFFFF_CAFE);

    // Same-cycle load and store: load sees pre-store data
    store(F3_W, 32'h4, 32'h55);
    drive(1'b1, 1'b1, F3_W, 32'h4, 32'h66);
    @(negedge clk);
    check("rbw_rd0", rd0, 32'h55);
    check("rbw_rdv0", {31'd0, rdv0}, 32'd1);
    step;
    check("rbw_rd1", rd1, 32'h55);
    check("rbw_rdv1", {31'd0, rdv1}, 32'd1);
    load("rbw_after", F3_W, 32'h4, 32'h66);
    idle;
    step;
    check("pulse_rdv1", {31'd0, rdv1}, 32'd0);
    check("hold_rd1", rd1, 32'h66);

    // Address wrap modulo DEPTH
    store(F3_W, 32'h40, 32'h1234_5678);
    load("alias0",  F3_W, 32'h0,  32'h1234_5678);
    load("alias40", F3_W, 32'h40, 32'h1234_5678);

    // Reset in the middle of the sweep restarts it; requests ignored while busy
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 3'b011, 32'h8, 32'hFFFF_FFFF);
      @(negedge clk);
      check("busy_err0", {31'd0, err0}, 32'd0);
      check("busy_rdv0", {31'd0, rdv0}, 32'd0);
      step;
      check("busy_rdv1", {31'd0, rdv1}, 32'd0);
    end
    idle;
    rst = 1'b1;
    step;
    rst = 1'b0;
    wait_ready(n_busy);
    check("resweep_cycles", n_busy, 32'd16);
    load("resweep_w0", F3_W, 32'h0, 32'h0);
    load("resweep_w8", F3_W, 32'h8, 32'h0);
    load("resweep_w4", F3_W, 32'h4, 32'h0);
    idle;
    step;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
